// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    WRITEBACK,
    DZERO
  } muldiv_state_e;

  // MultDiv result mux: multiplier HI/LO or divider remainder/quotient
  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-side bundle between the main FSM and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_W = 32
);

  logic              start_mult;
  logic              start_div;
  logic              abort;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mult_op;
  logic              div_op;
  logic              mult_div_sel;
  logic              hilo_write;
  logic              busy;
  logic              done;
  logic              div_zero;

  modport master (
    output start_mult, start_div, abort, op_a, op_b,
    input  mult_op, div_op, mult_div_sel, hilo_write, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, abort, op_a, op_b,
    output mult_op, div_op, mult_div_sel, hilo_write, busy, done, div_zero
  );

endinterface

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter timing out the multiply/divide unit latency.
module muldiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stops at zero so a stray dec can never wrap it
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the multiply/divide units and HI/LO write-back.
// Optional MULDIV_EARLY_OUT_EN: zero operands finish after a single run cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0]  MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  muldiv_state_e state_q, state_d;
  logic mult_op_q, mult_op_d;
  logic div_op_q, div_op_d;
  logic sel_q, sel_d;
  logic hilo_write_q, hilo_write_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic div_zero_q, div_zero_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_clear;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] mult_load_val;
  logic [CNT_W-1:0] div_load_val;
  logic             b_zero;

  assign b_zero = (bus.op_b == ZERO_WORD);

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [CNT_W-1:0] ONE_LOAD = CNT_W'(1);
  logic a_zero;
  assign a_zero        = (bus.op_a == ZERO_WORD);
  assign mult_load_val = (a_zero || b_zero) ? ONE_LOAD : MULT_LOAD;
  assign div_load_val  = a_zero ? ONE_LOAD : DIV_LOAD;
`else
  assign mult_load_val = MULT_LOAD;
  assign div_load_val  = DIV_LOAD;
`endif

  always_comb begin
    state_d      = state_q;
    mult_op_d    = 1'b0;
    div_op_d     = 1'b0;
    sel_d        = sel_q;
    cnt_load     = 1'b0;
    cnt_load_val = mult_load_val;
    cnt_dec      = 1'b0;
    cnt_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort outranks a coincident start; multiply outranks divide
        if (!bus.abort) begin
          if (bus.start_mult) begin
            state_d   = MULT_RUN;
            mult_op_d = 1'b1;
            sel_d     = SEL_MULT;
            cnt_load  = 1'b1;
          end else if (bus.start_div) begin
            if (b_zero) begin
              state_d = DZERO;
            end else begin
              state_d      = DIV_RUN;
              div_op_d     = 1'b1;
              sel_d        = SEL_DIV;
              cnt_load     = 1'b1;
              cnt_load_val = div_load_val;
            end
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (bus.abort) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK, DZERO: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase

    // Status outputs are decoded from the next state so they register alongside it
    busy_d       = (state_d != IDLE);
    hilo_write_d = (state_d == WRITEBACK);
    done_d       = (state_d == WRITEBACK);
    div_zero_d   = (state_d == DZERO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mult_op_q    <= 1'b0;
      div_op_q     <= 1'b0;
      sel_q        <= SEL_MULT;
      hilo_write_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mult_op_q    <= mult_op_d;
      div_op_q     <= div_op_d;
      sel_q        <= sel_d;
      hilo_write_q <= hilo_write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div_zero_q   <= div_zero_d;
    end
  end

  muldiv_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .last     (cnt_last)
  );

  assign bus.mult_op      = mult_op_q;
  assign bus.div_op       = div_op_q;
  assign bus.mult_div_sel = sel_q;
  assign bus.hilo_write   = hilo_write_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_zero     = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: timeline model plus directed latency checks.
module tb_muldiv_sequencer;

  localparam int N = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_WR = 2;
`else
  localparam int EO_WR = N + 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.DATA_W(32)) bus ();

  muldiv_sequencer #(
    .DATA_W      (32),
    .MULT_CYCLES (N),
    .DIV_CYCLES  (N),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: each accepted operation occupies a window of cycles after its start edge.
  // m_s = first cycle after the start edge; write-back lands m_n cycles later.
  int   cyc      = 0;
  int   m_s      = 0;
  int   m_n      = 0;
  int   m_kind   = 0;   // 0 multiply, 1 divide, 2 divide-by-zero
  bit   m_active = 1'b0;
  logic m_sel    = 1'b0;

  function automatic bit win(input int c);
    return m_active && (c >= m_s) && (c <= m_s + ((m_kind == 2) ? 0 : m_n));
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_active = 1'b0;
        m_sel    = 1'b0;
      end else begin
        if (win(cyc)) begin
          if (bus.abort) m_active = 1'b0;
        end else if (!bus.abort) begin
          if (bus.start_mult) begin
            m_active = 1'b1;
            m_kind   = 0;
            m_s      = cyc + 1;
            m_sel    = 1'b0;
            m_n      = N;
`ifdef MULDIV_EARLY_OUT_EN
            if (bus.op_a == 0 || bus.op_b == 0) m_n = 1;
`endif
          end else if (bus.start_div) begin
            m_active = 1'b1;
            m_s      = cyc + 1;
            if (bus.op_b == 0) begin
              m_kind = 2;
            end else begin
              m_kind = 1;
              m_sel  = 1'b1;
              m_n    = N;
`ifdef MULDIV_EARLY_OUT_EN
              if (bus.op_a == 0) m_n = 1;
`endif
            end
          end
        end
        cyc++;
      end
    end
  end

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cyc=%0d %s: got %b expected %b", cyc, name, act, exp);
    end
  endtask

  initial begin
    forever begin : cmp_blk
      logic w;
      @(negedge clk);
      w = win(cyc);
      cmp1("busy",         bus.busy,         w);
      cmp1("mult_op",      bus.mult_op,      w && m_kind == 0 && cyc == m_s);
      cmp1("div_op",       bus.div_op,       w && m_kind == 1 && cyc == m_s);
      cmp1("div_zero",     bus.div_zero,     w && m_kind == 2 && cyc == m_s);
      cmp1("hilo_write",   bus.hilo_write,   w && m_kind != 2 && cyc == m_s + m_n);
      cmp1("done",         bus.done,         w && m_kind != 2 && cyc == m_s + m_n);
      cmp1("mult_div_sel", bus.mult_div_sel, m_sel);
    end
  end

  // Observations of one operation, indexed by cycle after the start edge
  int o_wr_first, o_wr_cnt, o_wr_sel, o_done_cnt;
  int o_mop_first, o_mop_cnt, o_dop_first, o_dop_cnt;
  int o_dz_first, o_dz_cnt, o_busy_last;

  task automatic run_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input int rst_at, input int div2_at, input int ncyc);
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.abort      = (abort_at == 0);
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.abort      = 1'b0;
    o_wr_first = 0; o_wr_cnt = 0; o_wr_sel = -1; o_done_cnt = 0;
    o_mop_first = 0; o_mop_cnt = 0; o_dop_first = 0; o_dop_cnt = 0;
    o_dz_first = 0; o_dz_cnt = 0; o_busy_last = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        chk("async_reset_busy", int'(bus.busy), 0);
        chk("async_reset_hilo", int'(bus.hilo_write), 0);
      end
      if (bus.hilo_write) begin
        if (o_wr_first == 0) o_wr_first = k;
        o_wr_cnt++;
        o_wr_sel = int'(bus.mult_div_sel);
      end
      if (bus.done) o_done_cnt++;
      if (bus.mult_op) begin
        if (o_mop_first == 0) o_mop_first = k;
        o_mop_cnt++;
      end
      if (bus.div_op) begin
        if (o_dop_first == 0) o_dop_first = k;
        o_dop_cnt++;
      end
      if (bus.div_zero) begin
        if (o_dz_first == 0) o_dz_first = k;
        o_dz_cnt++;
      end
      if (bus.busy) o_busy_last = k;
      bus.abort     = (k == abort_at);
      bus.start_div = (k == div2_at);
      if (rst_at > 0 && k == rst_at + 2) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.abort     = 1'b0;
    bus.start_div = 1'b0;
    $display("op sm=%0b sd=%0b a=%0d b=%0d: wr@%0d x%0d sel=%0d mop@%0d dop@%0d dz@%0d busy_last=%0d",
             sm, sd, a, b, o_wr_first, o_wr_cnt, o_wr_sel, o_mop_first, o_dop_first, o_dz_first, o_busy_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.abort      = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",       int'(bus.busy),         0);
    chk("rst_mult_op",    int'(bus.mult_op),      0);
    chk("rst_div_op",     int'(bus.div_op),       0);
    chk("rst_hilo_write", int'(bus.hilo_write),   0);
    chk("rst_done",       int'(bus.done),         0);
    chk("rst_div_zero",   int'(bus.div_zero),     0);
    chk("rst_sel",        int'(bus.mult_div_sel), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // multiply 7*6
    run_op(1'b1, 1'b0, 32'd7, 32'd6, -1, -1, -1, 36);
    chk("mul_mop_first", o_mop_first, 1);
    chk("mul_mop_cnt",   o_mop_cnt,   1);
    chk("mul_wr_first",  o_wr_first,  33);
    chk("mul_wr_cnt",    o_wr_cnt,    1);
    chk("mul_done_cnt",  o_done_cnt,  1);
    chk("mul_wr_sel",    o_wr_sel,    0);
    chk("mul_busy_last", o_busy_last, 33);

    // divide 100/7
    run_op(1'b0, 1'b1, 32'd100, 32'd7, -1, -1, -1, 36);
    chk("div_dop_first", o_dop_first, 1);
    chk("div_mop_cnt",   o_mop_cnt,   0);
    chk("div_wr_first",  o_wr_first,  33);
    chk("div_wr_sel",    o_wr_sel,    1);
    chk("div_busy_last", o_busy_last, 33);

    // divide by zero
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, -1, -1, 5);
    chk("dz_first",     o_dz_first,  1);
    chk("dz_cnt",       o_dz_cnt,    1);
    chk("dz_dop_cnt",   o_dop_cnt,   0);
    chk("dz_wr_cnt",    o_wr_cnt,    0);
    chk("dz_done_cnt",  o_done_cnt,  0);
    chk("dz_busy_last", o_busy_last, 1);
    chk("dz_sel_hold",  int'(bus.mult_div_sel), 1);

    // simultaneous starts, then a divide request while busy
    run_op(1'b1, 1'b1, 32'd9, 32'd6, -1, -1, 5, 36);
    chk("both_mop_cnt",  o_mop_cnt,  1);
    chk("both_dop_cnt",  o_dop_cnt,  0);
    chk("both_wr_first", o_wr_first, 33);
    chk("both_wr_cnt",   o_wr_cnt,   1);
    chk("both_wr_sel",   o_wr_sel,   0);

    // abort mid-run
    run_op(1'b1, 1'b0, 32'd7, 32'd6, 10, -1, -1, 36);
    chk("abt_wr_cnt",    o_wr_cnt,    0);
    chk("abt_done_cnt",  o_done_cnt,  0);
    chk("abt_busy_last", o_busy_last, 10);

    // abort in the cycle that would enter write-back
    run_op(1'b1, 1'b0, 32'd3, 32'd5, 32, -1, -1, 36);
    chk("abt32_wr_cnt",    o_wr_cnt,    0);
    chk("abt32_busy_last", o_busy_last, 32);

    // abort coincident with start in idle
    run_op(1'b1, 1'b0, 32'd3, 32'd5, 0, -1, -1, 4);
    chk("abt0_mop_cnt",   o_mop_cnt,   0);
    chk("abt0_busy_last", o_busy_last, 0);

    // reset mid-run
    run_op(1'b1, 1'b0, 32'd7, 32'd6, -1, 20, -1, 36);
    chk("rst_wr_cnt",    o_wr_cnt,    0);
    chk("rst_done_cnt",  o_done_cnt,  0);
    chk("rst_busy_last", o_busy_last, 19);

    // zero operands: early-out when enabled, full latency otherwise
    run_op(1'b1, 1'b0, 32'd0, 32'd6, -1, -1, -1, 36);
    chk("eo_mul_wr_first",  o_wr_first,  EO_WR);
    chk("eo_mul_busy_last", o_busy_last, EO_WR);
    run_op(1'b0, 1'b1, 32'd0, 32'd9, -1, -1, -1, 36);
    chk("eo_div_wr_first", o_wr_first, EO_WR);
    chk("eo_div_wr_sel",   o_wr_sel,   1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Controller for the multiply and divide units and the HI/LO register pair. It accepts a one-cycle start request from the main control FSM and pulses the start input of the selected unit. It counts out the unit's fixed latency, then drives the HI/LO write enable and the MultDiv result-select mux. It detects divide-by-zero before any work starts, and holds busy high so the main control can stall.

Parameters:
DATA_W, 32, operand width
MULT_CYCLES, 32, multiply unit latency in cycles (must be >= 1)
DIV_CYCLES, 32, divide unit latency in cycles (must be >= 1)
CNT_W, 6, counter width (must hold max(MULT_CYCLES, DIV_CYCLES))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start_mult  in  1  one-cycle request: begin multiply
start_div  in  1  one-cycle request: begin divide
abort  in  1  cancel the current operation (exception flush)
op_a  in  DATA_W  operand A, valid in the start cycle
op_b  in  DATA_W  operand B / divisor, valid in the start cycle
mult_op  out  1  start pulse to the multiply unit
div_op  out  1  start pulse to the divide unit
mult_div_sel  out  1  MultDiv select: 0 = mult HI/LO, 1 = div remainder/quotient
hilo_write  out  1  HI/LO register write enable
busy  out  1  operation in progress; main control stalls
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- All outputs are registered. While reset=0, all outputs and the counter are 0 and state = IDLE, asynchronously.
- States: IDLE, MULT_RUN, DIV_RUN, WRITEBACK, DZERO.
- IDLE, start_mult=1 at edge E0:
  - go to MULT_RUN, load cnt=MULT_CYCLES.
  - mult_op=1 for exactly the cycle after E0.
  - mult_div_sel=0, busy=1.
- IDLE, start_div=1 and start_mult=0:
  - op_b==0: go to DZERO; div_zero=1 and busy=1 for one cycle; then IDLE. No div_op, no hilo_write, no done.
  - op_b!=0: go to DIV_RUN, load cnt=DIV_CYCLES; div_op pulses one cycle; mult_div_sel=1, busy=1.
- start_mult and start_div in the same cycle: multiply wins; start_div is dropped.
- MULT_RUN/DIV_RUN: cnt decrements every edge. When cnt==1, go to WRITEBACK. RUN therefore lasts exactly N cycles.
- WRITEBACK: hilo_write=1 and done=1 for one cycle; mult_div_sel stays stable; busy=1. Next state is IDLE, where busy=0.
- Latency from start edge to hilo_write cycle = N+1 cycles (33 at defaults).
- mult_div_sel holds its last value in IDLE and changes only on an accepted start.
- start_* while busy=1: ignored, no queueing.
- abort=1 in any non-IDLE state:
  - next state is IDLE; cnt cleared.
  - hilo_write, done and div_zero are suppressed, even if abort arrives in the WRITEBACK-entry cycle.
  - abort has priority over start in IDLE.
- Reset mid-operation: immediate return to IDLE with outputs 0. HI/LO are not written.
- The counter never wraps; the load value is always >= 1.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: a multiply with op_a==0 or op_b==0 loads cnt=1, so hilo_write occurs 2 cycles after the start edge. Divide with op_a==0 (and op_b!=0) behaves the same way.
- Undefined: latency is always fixed at N+1; operand values affect only divide-by-zero detection.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum (IDLE, MULT_RUN, DIV_RUN, WRITEBACK, DZERO);
  - the MultDiv select constants SEL_MULT=0, SEL_DIV=1;
  - default latency constants.
- One sub-module, muldiv_cycle_counter: a loadable down-counter with load, dec, clear and a last (cnt==1) flag.

Test Plan:
- start_mult, op_a=7, op_b=6 at E0 -> mult_op high in cycle 1 only; busy high in cycles 1-33; hilo_write=done=1 in cycle 33 with mult_div_sel=0; busy=0 in cycle 34.
- start_div, op_a=100, op_b=7 -> div_op pulse in cycle 1; hilo_write in cycle 33 with mult_div_sel=1.
- start_div, op_b=0 -> div_zero=1 in cycle 1 only; no div_op or hilo_write; busy=0 in cycle 2.
- start_mult and start_div together, then start_div at cycle 5 -> multiply runs; the second request is ignored; exactly one hilo_write, in cycle 33.
- abort at cycle 10 of a multiply; separately, reset=0 at cycle 20 -> state IDLE; busy=0 the next cycle or immediately on reset; no hilo_write or done.
- MULDIV_EARLY_OUT_EN defined, multiply with op_a=0 -> hilo_write in cycle 2. Undefined -> cycle 33.
